// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - shared types and opcode constants for the immediate generator
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_SH   = 3'd5,
        FMT_NONE = 3'd7
    } imm_fmt_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/imm_decode.sv
// rtl/imm_decode.sv - combinational RV32I/RV64I immediate decoder
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    logic [2:0] funct3;
    assign funct3 = instr[14:12];

    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (instr[6:0])
            OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                fmt = FMT_I;
                imm = XLEN'($signed(instr[31:20]));
            end
            OPC_OPIMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    // shamt widens to 6 bits on RV64; funct7 bits are not part of the value
                    fmt = FMT_SH;
                    if (XLEN == 64) imm = XLEN'(instr[25:20]);
                    else            imm = XLEN'(instr[24:20]);
                end else begin
                    fmt = FMT_I;
                    imm = XLEN'($signed(instr[31:20]));
                end
            end
            OPC_STORE: begin
                fmt = FMT_S;
                imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            end
            OPC_BRANCH: begin
                fmt = FMT_B;
                imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt = FMT_U;
                imm = XLEN'($signed({instr[31:12], 12'b0}));
            end
            OPC_JAL: begin
                fmt = FMT_J;
                imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - handshaked immediate generator with output register and one skid entry
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output imm_fmt_e         out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0]  dec_imm;
    imm_fmt_e         dec_fmt;
    logic             dec_illegal;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    skid_state_e      state, state_next;
    logic             ready_q;
    logic [XLEN-1:0]  skid_imm;
    imm_fmt_e         skid_fmt;
    logic             skid_illegal;
    logic [TAG_W-1:0] skid_tag;

    logic in_fire, out_fire;
    logic load_out_in, load_out_skid, load_skid;

    assign in_ready  = ready_q;
    assign out_valid = (state != ST_EMPTY);
    assign in_fire   = in_valid & ready_q;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_next    = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_next  = ST_ONE;
                        load_out_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        load_out_in = 1'b1;
                    end else if (in_fire) begin
                        state_next = ST_TWO;
                        load_skid  = 1'b1;
                    end else if (out_fire) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // older entry sits in the output register, so drain refills it from the skid
                    if (out_fire) begin
                        state_next    = ST_ONE;
                        load_out_skid = 1'b1;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_EMPTY;
            ready_q      <= 1'b1;
            out_imm      <= '0;
            out_fmt      <= FMT_NONE;
            out_illegal  <= 1'b0;
            out_tag      <= '0;
            skid_imm     <= '0;
            skid_fmt     <= FMT_NONE;
            skid_illegal <= 1'b0;
            skid_tag     <= '0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next != ST_TWO);
            if (load_out_in) begin
                out_imm     <= dec_imm;
                out_fmt     <= dec_fmt;
                out_illegal <= dec_illegal;
                out_tag     <= in_tag;
            end else if (load_out_skid) begin
                out_imm     <= skid_imm;
                out_fmt     <= skid_fmt;
                out_illegal <= skid_illegal;
                out_tag     <= skid_tag;
            end
            if (load_skid) begin
                skid_imm     <= dec_imm;
                skid_fmt     <= dec_fmt;
                skid_illegal <= dec_illegal;
                skid_tag     <= in_tag;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed self-checking bench for imm_gen_pipe (XLEN 32 and 64)
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;
    logic [31:0] out_tag;

    logic        in_valid64;
    logic        in_ready64;
    logic [31:0] in_instr64;
    logic [31:0] in_tag64;
    logic        out_valid64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic        out_illegal64;
    logic [31:0] out_tag64;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
        .out_illegal(out_illegal), .out_tag(out_tag)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64), .in_tag(in_tag64),
        .out_valid(out_valid64), .out_ready(1'b1), .out_imm(out_imm64), .out_fmt(out_fmt64),
        .out_illegal(out_illegal64), .out_tag(out_tag64)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b1;
        in_valid64 = 1'b0; in_instr64 = '0; in_tag64 = '0;
        step(); step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        tests++; if (out_imm !== 32'h0) begin fails++; $display("FAIL reset_out_imm got %h want 0", out_imm); end
        tests++; if (out_fmt !== 3'd7) begin fails++; $display("FAIL reset_out_fmt got %0d want 7", out_fmt); end
        tests++; if (out_illegal !== 1'b0 || out_tag !== 32'h0) begin
            fails++; $display("FAIL reset_ill_tag got %b/%h want 0/0", out_illegal, out_tag); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_addi();
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 32'h1000;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL addi_in_ready got %b want 1", in_ready); end
        step();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFF || out_fmt !== 3'd0 ||
                     out_illegal !== 1'b0 || out_tag !== 32'h1000) begin
            fails++; $display("FAIL addi got v=%b imm=%h fmt=%0d ill=%b tag=%h want 1 ffffffff 0 0 1000",
                              out_valid, out_imm, out_fmt, out_illegal, out_tag); end
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL addi_drain got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [7] = '{32'hFE000EE3, 32'h123450B7, 32'h0080006F, 32'h00F09093,
                                 32'h0000007F, 32'hFE112E23, 32'h4030D093};
        logic [31:0] imm [7] = '{32'hFFFFFFFC, 32'h12345000, 32'h00000008, 32'h0000000F,
                                 32'h00000000, 32'hFFFFFFFC, 32'h00000003};
        logic [2:0]  fmt [7] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd7, 3'd1, 3'd5};
        logic        ill [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_instr = ins[i]; in_tag = 32'h2000 + 32'(4 * i);
            step();
            tests++;
            if (out_valid !== 1'b1 || out_imm !== imm[i] || out_fmt !== fmt[i] ||
                out_illegal !== ill[i] || out_tag !== 32'h2000 + 32'(4 * i) || in_ready !== 1'b1) begin
                fails++; $display("FAIL b2b_%0d got v=%b imm=%h fmt=%0d ill=%b tag=%h rdy=%b want imm=%h fmt=%0d ill=%b",
                                  i, out_valid, out_imm, out_fmt, out_illegal, out_tag, in_ready, imm[i], fmt[i], ill[i]);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 32'hA;
        step();
        in_instr = 32'h123450B7; in_tag = 32'hB;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_b got %b want 1", in_ready); end
        step();
        in_instr = 32'h0080006F; in_tag = 32'hC;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_c got %b want 0", in_ready); end
        step();
        tests++; if (out_valid !== 1'b1 || out_tag !== 32'hA || out_imm !== 32'hFFFFFFFF || in_ready !== 1'b0) begin
            fails++; $display("FAIL bp_hold got v=%b tag=%h imm=%h rdy=%b want 1 a ffffffff 0",
                              out_valid, out_tag, out_imm, in_ready); end
        out_ready = 1'b1;
        step();
        tests++; if (out_valid !== 1'b1 || out_tag !== 32'hB || out_imm !== 32'h12345000 || in_ready !== 1'b1) begin
            fails++; $display("FAIL bp_out_b got v=%b tag=%h imm=%h rdy=%b want 1 b 12345000 1",
                              out_valid, out_tag, out_imm, in_ready); end
        step();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_tag !== 32'hC || out_imm !== 32'h00000008) begin
            fails++; $display("FAIL bp_out_c got v=%b tag=%h imm=%h want 1 c 8", out_valid, out_tag, out_imm); end
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 32'hF1;
        step();
        in_tag = 32'hF2;
        step();
        in_tag = 32'hF3; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL flush_two got v=%b rdy=%b want 0 1", out_valid, in_ready); end
        in_valid = 1'b1; in_tag = 32'hF4;
        step();
        in_tag = 32'hF5; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_one got v=%b want 0", out_valid); end
        step();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_ghost got v=%b tag=%h want 0", out_valid, out_tag); end
        in_valid = 1'b1; in_instr = 32'h123450B7; in_tag = 32'hF6;
        step();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_tag !== 32'hF6) begin
            fails++; $display("FAIL flush_after got v=%b tag=%h want 1 f6", out_valid, out_tag); end
        step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 32'hE1;
        step();
        in_tag = 32'hE2;
        step();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_tag !== 32'h0) begin
            fails++; $display("FAIL async_rst got v=%b rdy=%b tag=%h want 0 1 0", out_valid, in_ready, out_tag); end
        step();
        rst = 1'b0; out_ready = 1'b1;
        step();
        in_valid = 1'b1; in_instr = 32'hFE000EE3; in_tag = 32'hE3;
        step();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_tag !== 32'hE3 || out_imm !== 32'hFFFFFFFC) begin
            fails++; $display("FAIL rst_latency got v=%b tag=%h imm=%h want 1 e3 fffffffc", out_valid, out_tag, out_imm); end
        step();
    endtask

    task automatic test_xlen64();
        logic [31:0] ins [3] = '{32'hFFF00093, 32'h800000B7, 32'h02F09093};
        logic [63:0] imm [3] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF80000000, 64'h000000000000002F};
        logic [2:0]  fmt [3] = '{3'd0, 3'd3, 3'd5};
        for (int i = 0; i < 3; i++) begin
            in_valid64 = 1'b1; in_instr64 = ins[i]; in_tag64 = 32'h6400 + 32'(i);
            step();
            tests++;
            if (out_valid64 !== 1'b1 || out_imm64 !== imm[i] || out_fmt64 !== fmt[i] ||
                out_illegal64 !== 1'b0 || out_tag64 !== 32'h6400 + 32'(i)) begin
                fails++; $display("FAIL x64_%0d got v=%b imm=%h fmt=%0d ill=%b tag=%h want imm=%h fmt=%0d",
                                  i, out_valid64, out_imm64, out_fmt64, out_illegal64, out_tag64, imm[i], fmt[i]);
            end
        end
        in_valid64 = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_xlen64();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
